// File: rtl/mips_cache_pkg.sv
// Shared types and helpers for the N-way write-through data cache.
// Holds the miss FSM state type, byte-merge and address field widths.
package mips_cache_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Tag covers everything above the word offset and the set index.
    function automatic int tag_width(input int set_bits);
        return 30 - set_bits;
    endfunction

    // A tree over N ways has N-1 nodes; keep one dummy bit when direct-mapped.
    function automatic int plru_width(input int way_bits);
        return (way_bits == 0) ? 1 : (2 ** way_bits) - 1;
    endfunction

    // Way index width, never zero so ports stay legal when direct-mapped.
    function automatic int way_idx_width(input int way_bits);
        return (way_bits == 0) ? 1 : way_bits;
    endfunction

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_cache_plru.sv
// Tree pseudo-LRU for one set: victim select and next-state on access.
// Ports: bits/valid (current set state), access_way -> victim, next_bits.
module mips_cache_plru
    import mips_cache_pkg::*;
#(
    parameter int WAY_BITS = 2,
    localparam int WAYS = 2 ** WAY_BITS,
    localparam int PW = plru_width(WAY_BITS),
    localparam int WB = way_idx_width(WAY_BITS)
) (
    input  logic [PW-1:0]   bits,
    input  logic [WAYS-1:0] valid,
    input  logic [WB-1:0]   access_way,
    output logic [WB-1:0]   victim,
    output logic [PW-1:0]   next_bits
);

    // Nodes are heap-ordered: root 0, children of n at 2n+1 / 2n+2.
    // A node bit of 0 means the victim lies in the lower half.
    always_comb begin
        logic found;
        int   node;
        victim = '0;
        found  = 1'b0;
        node   = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid[w]) begin
                victim = WB'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int l = 0; l < WAY_BITS; l++) begin
                victim[WAY_BITS-1-l] = bits[node];
                node = 2 * node + 1 + int'(bits[node]);
            end
        end
    end

    // Each node on the accessed way's path is pointed at the other half.
    always_comb begin
        int   node;
        logic b;
        next_bits = bits;
        node      = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            b               = access_way[WAY_BITS-1-l];
            next_bits[node] = ~b;
            node            = 2 * node + 1 + int'(b);
        end
    end

endmodule

// File: rtl/mips_cache_data_nway.sv
// N-way set-associative write-through L1 data cache with tree PLRU.
// Ports: CPU side (addr, read_en, write_en, writedata, byte_en, flush,
// readdata, stall), Avalon-style memory side (mem_*), hit/miss counters.
module mips_cache_data_nway
    import mips_cache_pkg::*;
#(
    parameter int SET_BITS = 3,
    parameter int WAY_BITS = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic             read_en,
    input  logic             write_en,
    input  logic [31:0]      writedata,
    input  logic [3:0]       byte_en,
    input  logic             flush,
    output logic [31:0]      readdata,
    output logic             stall,
    output logic [31:0]      mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_writedata,
    output logic [3:0]       mem_byteenable,
    input  logic             mem_waitrequest,
    input  logic             mem_readdatavalid,
    input  logic [31:0]      mem_readdata,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int SETS  = 2 ** SET_BITS;
    localparam int WAYS  = 2 ** WAY_BITS;
    localparam int TAG_W = tag_width(SET_BITS);
    localparam int PW    = plru_width(WAY_BITS);
    localparam int WB    = way_idx_width(WAY_BITS);

    state_t state;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [PW-1:0]    plru_q  [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [31:0]      data_q  [SETS][WAYS];

    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    tag;
    logic                addr_unused;

    logic          hit;
    logic [WB-1:0] hit_way;
    logic [WB-1:0] victim;
    logic [WB-1:0] acc_way;
    logic [PW-1:0] plru_next;
    logic [31:0]   hit_data;

    logic idle, do_flush, rd_hit, wr_go;
    logic wr_hit, wr_alloc, wr_miss, fill;
    logic touch, inc_hit, inc_miss;

    assign idx         = addr[2+SET_BITS-1:2];
    assign tag         = addr[31:2+SET_BITS];
    assign addr_unused = ^addr[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        end
    end

    assign hit_data = data_q[idx][hit_way];
    assign acc_way  = hit ? hit_way : victim;

    mips_cache_plru #(
        .WAY_BITS(WAY_BITS)
    ) u_plru (
        .bits      (plru_q[idx]),
        .valid     (valid_q[idx]),
        .access_way(acc_way),
        .victim    (victim),
        .next_bits (plru_next)
    );

    // A flush in IDLE takes the cycle; any request waits for the next one.
    assign idle     = (state == IDLE);
    assign do_flush = idle & flush;
    assign rd_hit   = idle & ~flush & read_en & hit;
    assign wr_go    = idle & ~flush & write_en;
    assign wr_hit   = wr_go & hit & (|byte_en);
    assign wr_alloc = wr_go & ~hit & (byte_en == 4'hF);
    assign wr_miss  = wr_go & ~hit & (|byte_en);
    assign fill     = (state == RD_WAIT) & mem_readdatavalid;
    assign touch    = rd_hit | wr_hit | wr_alloc | fill;
    assign inc_hit  = rd_hit | wr_hit;
    assign inc_miss = wr_miss | fill;

    assign stall = (read_en | write_en) & (state != RESP) & ~rd_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!flush) begin
                        if (read_en && !hit)
                            state <= RD_REQ;
                        else if (write_en)
                            state <= (byte_en == 4'h0) ? RESP : WR_REQ;
                    end
                end
                RD_REQ:  if (!mem_waitrequest) state <= RD_WAIT;
                RD_WAIT: if (mem_readdatavalid) state <= RESP;
                WR_REQ:  if (!mem_waitrequest) state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (do_flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (touch)
                plru_q[idx] <= plru_next;
            if (wr_alloc || fill)
                valid_q[idx][victim] <= 1'b1;
        end
    end

    // Tag/data need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill || wr_alloc) begin
            tag_q[idx][victim]  <= tag;
            data_q[idx][victim] <= fill ? mem_readdata : writedata;
        end else if (wr_hit) begin
            data_q[idx][hit_way] <= byte_merge(hit_data, writedata, byte_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            readdata <= '0;
        else if (rd_hit)
            readdata <= hit_data;
        else if (fill)
            readdata <= mem_readdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (inc_hit && hit_count != '1)
                hit_count <= hit_count + CNT_W'(1);
            if (inc_miss && miss_count != '1)
                miss_count <= miss_count + CNT_W'(1);
        end
    end

    always_comb begin
        mem_read       = (state == RD_REQ);
        mem_write      = (state == WR_REQ);
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        if (mem_read) begin
            mem_address    = {addr[31:2], 2'b00};
            mem_byteenable = 4'hF;
        end else if (mem_write) begin
            mem_address    = {addr[31:2], 2'b00};
            mem_writedata  = writedata;
            mem_byteenable = byte_en;
        end
    end

endmodule

// File: doc/mips_cache_data_nway.md
Name: mips_cache_data_nway

Overview:
Parametrised N-way set-associative, write-through L1 data cache with tree pseudo-LRU replacement. It sits between the MIPS CPU data port and the Avalon-style data memory bus. It generalises the fixed 4-way data cache to power-of-two associativity and set count. It owns the memory handshake itself, with a miss FSM, and adds flush and hit/miss counters.

Parameters:
SET_BITS, 3, log2 number of sets (SETS = 2**SET_BITS); one 32-bit word per line.
WAY_BITS, 2, log2 associativity (WAYS = 2**WAY_BITS, 1..4 bits); PLRU tree has WAYS-1 bits per set.
CNT_W, 32, width of the hit/miss counters (saturating).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
addr  in  32  CPU byte address; bits [1:0] ignored.
read_en  in  1  CPU read request, held until stall low.
write_en  in  1  CPU write request, held until stall low; never asserted together with read_en.
writedata  in  32  CPU write data.
byte_en  in  4  CPU byte enables.
flush  in  1  invalidate all lines.
readdata  out  32  read result, registered.
stall  out  1  CPU must hold its request while high (combinational).
mem_address  out  32  word-aligned memory address.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
mem_writedata  out  32  memory write data.
mem_byteenable  out  4  memory byte enables.
mem_waitrequest  in  1  memory not accepting request.
mem_readdatavalid  in  1  mem_readdata valid this cycle.
mem_readdata  in  32  memory read data.
hit_count  out  CNT_W  completed hits.
miss_count  out  CNT_W  completed misses.

Behaviour:
- Address split: index = addr[2+SET_BITS-1:2]; tag = addr[31:2+SET_BITS]. Hit = any valid way with a matching tag (at most one).
- Reset: all valid and PLRU bits clear; state IDLE; readdata=0; all mem_* outputs 0; counters 0; stall=0 with no request. Reset mid-operation aborts the transaction immediately. A late mem_readdatavalid arriving in IDLE is ignored.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- stall = (state != RESP) & (read_en | write_en), except it is 0 in IDLE on a read hit. stall is 1 in any cycle flush is high while a request is present.
- IDLE, read hit: stall=0; readdata <= hit way data at the edge; PLRU updated; hit_count++. Zero-wait access.
- IDLE, read miss: go to RD_REQ.
  - RD_REQ: mem_read=1, mem_address={addr[31:2],2'b00}, mem_byteenable=4'hF. Advance to RD_WAIT on an edge with mem_waitrequest=0.
  - RD_WAIT: on mem_readdatavalid, fill the victim way (tag, data, valid=1), update PLRU, readdata <= mem_readdata, miss_count++, go to RESP.
- IDLE, write: go to WR_REQ. At that edge the cache array is updated:
  - Hit: merge writedata per byte_en into the hit way; update PLRU; hit_count++.
  - Miss with byte_en=4'hF: allocate the victim way with writedata; update PLRU; miss_count++.
  - Miss with a partial byte_en: no allocation; miss_count++.
- Write with byte_en=0: the cache array is untouched and no memory write is issued. The cache goes straight to RESP with no counter change.
- WR_REQ: mem_write=1, mem_writedata=writedata, mem_byteenable=byte_en. Go to RESP on an edge with mem_waitrequest=0. The policy is write-through, so memory is always updated.
- RESP: stall=0 for exactly one cycle; the request is consumed; return to IDLE. The CPU drops or changes its request at the next edge.
- Victim selection: the lowest-index invalid way if one exists. Otherwise walk the tree from the root, where node bit 0 means the victim lies in the lower half.
- PLRU update on an access to way w: every node on w's path is set to point away from w.
- flush: honoured only in IDLE; clears all valid and PLRU bits in one cycle. Any simultaneous request is not serviced that cycle and is retried in IDLE next cycle. flush in other states is ignored.
- Counters saturate at all-ones.
- WAY_BITS=0 (direct-mapped) is legal: no PLRU bits, victim = way 0.

Decomposition:
- Package mips_cache_pkg holds:
  - the state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP);
  - the byte-merge function (old word, new word, byte_en);
  - address field width helpers.
- Sub-module mips_cache_plru: combinational victim select (inputs: PLRU bits, valid vector) and next-PLRU computation (inputs: current bits, accessed way), parametrised by WAY_BITS.

Test Plan:
1. After reset, read 0x100; memory returns 0xDEADBEEF after 3 waitrequest cycles and 2 cycles latency.
   - stall stays high; readdata=0xDEADBEEF in RESP; miss_count=1.
   - Re-reading 0x100 has stall=0 and hit_count=1.
2. Five reads with the same index and distinct tags (0x000, 0x020, 0x040, 0x060, 0x080 at SET_BITS=3), then re-read 0x000 to force a refill.
   - Invalid ways fill 0,1,2,3 in order.
   - The fifth read evicts way 0 by tree-PLRU.
   - Re-reading 0x000 misses.
3. Write hit to a cached 0x11223344 with byte_en=4'b0010, writedata=0x0000AA00.
   - mem_write is issued with byteenable 0010.
   - A subsequent read hit returns 0x1122AA44.
4. Write misses:
   - Partial write miss (byte_en=0011) to 0x200: no allocation; the next read of 0x200 misses.
   - Full-word write miss to 0x300: allocates; the next read of 0x300 hits without bus activity.
5. flush asserted in IDLE together with read_en to a cached address.
   - stall=1 that cycle.
   - The next cycle misses, and mem_read is asserted in RD_REQ.
6. rst pulsed asynchronously during RD_WAIT.
   - mem_read is 0 and state is IDLE immediately; readdata=0; counters are 0.
   - A subsequent stray mem_readdatavalid is ignored.
